// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//
// This is a bit-serial adder sequencer. A start pulse captures two WIDTH-bit
// operands. The operands are then pushed LSB-first through a single 1-bit
// full adder cell, one bit per clock, over WIDTH cycles. A carry flip-flop
// closes the loop between cycles. When the last bit has been processed, the
// result is loaded into sum/cout and done pulses for one cycle.
//
// Optional feature (compile-time macro SERIAL_SUB_EN):
//   This macro adds a 'sub' input. When sub=1 on an accepted start, operand B
//   is loaded inverted and the carry is seeded with 1, so the result is
//   a - b mod 2^WIDTH. In that case cout=1 means no borrow (a >= b unsigned).
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  operation request, only sampled in IDLE
//   sub    (SERIAL_SUB_EN only) subtract select, captured with the operands
//   a, b   operands, captured on an accepted start
//   busy   high while bits are being processed
//   done   single-cycle pulse, sum/cout hold the new result
//   sum    registered result, holds until the next completion
//   cout   registered carry out of the MSB position
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // WIDTH >= 2 guarantees at least one counter bit.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             load, step, last;
  logic             sub_op;
  logic [WIDTH-1:0] b_init;
  logic [1:0]       fa_out;   // {co, s}

  // This is the 1-bit full adder cell. It returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

`ifdef SERIAL_SUB_EN
  assign sub_op = sub;
`else
  assign sub_op = 1'b0;
`endif

  // Subtraction is a + ~b + 1. The +1 comes from seeding the carry.
  assign b_init = sub_op ? ~b : b;
  assign fa_out = full_add(a_sh[0], b_sh[0], carry);

  // busy/done decode directly from the state register, so they are
  // glitch-free and mutually exclusive.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- control and result registers (reset) ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        carry <= sub_op;
        cnt   <= '0;
      end else if (step) begin
        carry <= fa_out[1];
        cnt   <= cnt + CW'(1);
      end
      if (last) begin
        sum  <= {fa_out[0], r_sh[WIDTH-1:1]};
        cout <= fa_out[1];
      end
    end
  end

  // ---- operand/result shift registers (no reset) ----
  // These registers are only observed through sum after a full RUN pass, so
  // their power-up contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (load) begin
      a_sh <= a;
      b_sh <= b_init;
    end else if (step) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
      r_sh <= {fa_out[0], r_sh[WIDTH-1:1]};
    end
  end

endmodule
